fixed_latency_stream_adapter: RTL and testbench

Valid/ready wrapper that lets a non-stallable, fixed-latency arithmetic pipeline (e.g. the FP64 datapath behind the `a**5 + 0.3*b - c` challenge) serve a backpressured stream interface. It sits between the upstream argument producer and the downstream result consumer. It tracks in-flight operations, captures pipeline outputs into an internal result FIFO, and withholds `arg_rdy` (credit-based) so no result is ever lost under `res_rdy` backpressure. The arithmetic pipeline is external; this block issues operations and collects their results.

---
 rtl/fixed_latency_stream_adapter.sv | 131 +++++++++++++
 tb/tb_fixed_latency_stream_adapter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_latency_stream_adapter.sv
// -----------------------------------------------------------------------------
// fixed_latency_stream_adapter
//
// Wraps a non-stallable, fixed-latency external pipeline so that it can serve
// a valid/ready stream. Every accepted operation takes a credit, which is held
// until its result is popped downstream. Credits are capped at DEPTH, so the
// result FIFO can always absorb whatever the pipeline produces, even when the
// consumer stalls.
//
// Parameters
//   W        result data width
//   LATENCY  issue-to-result latency of the external pipeline (>= 1)
//   DEPTH    result FIFO depth and credit limit (>= 1)
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous active-high reset
//   arg_vld     upstream offers an operation (operands go straight to the pipe)
//   arg_rdy     adapter can take an operation this cycle
//   pipe_issue  operation enters the pipeline this cycle (arg_vld & arg_rdy)
//   pipe_res    pipeline output, valid LATENCY cycles after pipe_issue
//   res_vld     FIFO head is valid
//   res_rdy     downstream accepts the head
//   res         FIFO head data
// -----------------------------------------------------------------------------
module fixed_latency_stream_adapter #(
    parameter int W       = 64,
    parameter int LATENCY = 10,
    parameter int DEPTH   = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arg_vld,
    output logic         arg_rdy,
    output logic         pipe_issue,
    input  logic [W-1:0] pipe_res,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [W-1:0] res
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Credits in use: issued and not yet popped, whether in flight or queued.
    logic [OW-1:0]      occ_q, occ_d;
    // Bit i set: an operation was issued i+1 cycles ago.
    logic [LATENCY-1:0] trk_q, trk_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]      cnt_q, cnt_d;
    logic [W-1:0]       mem_q [DEPTH];

    logic wr_en;
    logic pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        occ_d    = occ_q;
        trk_d    = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        // Ready depends on the registered credit count only.
        arg_rdy    = !rst && (occ_q < OW'(DEPTH));
        pipe_issue = arg_vld && arg_rdy;
        res_vld    = !rst && (cnt_q != '0);
        pop        = res_vld && res_rdy;
        // Tracker top bit marks the cycle the pipeline output is valid.
        wr_en      = trk_q[LATENCY-1];
        res        = mem_q[rd_ptr_q];

        if (pipe_issue && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!pipe_issue && pop) begin
            occ_d = occ_q - OW'(1);
        end

        trk_d[0] = pipe_issue;
        for (int i = 1; i < LATENCY; i++) begin
            trk_d[i] = trk_q[i-1];
        end

        // occ <= DEPTH bounds the FIFO count, so a write never finds it full.
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (wr_en && !pop) begin
            cnt_d = cnt_q + OW'(1);
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - OW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= '0;
            trk_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            occ_q    <= occ_d;
            trk_q    <= trk_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers decide which entries
    // are meaningful, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= pipe_res;
        end
    end

endmodule

// File: tb/tb_fixed_latency_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_fixed_latency_stream_adapter
//
// Self-checking bench. The external pipeline is modelled as a LATENCY-stage
// register chain of the argument payload. The reference model is a queue of
// accepted payloads, each tagged with the cycle from which its result may be
// presented (issue cycle + LATENCY + 1); readiness follows from the queue size.
// -----------------------------------------------------------------------------
module tb_fixed_latency_stream_adapter;

    localparam int W       = 64;
    localparam int LATENCY = 10;
    localparam int DEPTH   = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         arg_vld = 1'b0;
    logic         arg_rdy;
    logic         pipe_issue;
    logic [W-1:0] pipe_res;
    logic         res_vld;
    logic         res_rdy = 1'b0;
    logic [W-1:0] res;
    logic [W-1:0] arg_data = '0;

    fixed_latency_stream_adapter #(.W(W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .arg_vld    (arg_vld),
        .arg_rdy    (arg_rdy),
        .pipe_issue (pipe_issue),
        .pipe_res   (pipe_res),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy),
        .res        (res)
    );

    always #5 clk = ~clk;

    // External pipeline: non-stallable register chain of the operand payload.
    logic [W-1:0] stg [LATENCY];
    always @(posedge clk) begin
        stg[0] <= arg_data;
        for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
    assign pipe_res = stg[LATENCY-1];

    // Reference model state.
    logic [W-1:0] sb_q [$];
    int           av_q [$];
    int           cyc   = 0;
    int           n_iss = 0;
    int           n_pop = 0;
    int           total = 0;
    int           bad   = 0;
    logic         obs_rdy, obs_vld, last_pop, last_issue;
    logic [W-1:0] obs_res;

    // A pipeline write into a full FIFO must never happen.
    always @(posedge clk) begin
        if (!rst && dut.wr_en && dut.cnt_q == DEPTH) begin
            bad++;
            $display("FAIL fifo_full_write cyc=%0d count=%0d limit=%0d", cyc, dut.cnt_q, DEPTH);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d expired", cyc);
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive at negedge, compare just before the rising edge,
    // then advance the model by what the handshakes did in this cycle.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, input logic rr);
        logic exp_rdy, exp_vld;
        @(negedge clk);
        rst = r; arg_vld = v; arg_data = d; res_rdy = rr;
        #4;
        exp_rdy = !r && (sb_q.size() < DEPTH);
        exp_vld = !r && (sb_q.size() > 0) && (av_q[0] <= cyc);
        total++;
        if (arg_rdy !== exp_rdy) begin
            bad++; $display("FAIL arg_rdy cyc=%0d got=%b exp=%b", cyc, arg_rdy, exp_rdy);
        end
        total++;
        if (res_vld !== exp_vld) begin
            bad++; $display("FAIL res_vld cyc=%0d got=%b exp=%b", cyc, res_vld, exp_vld);
        end
        total++;
        if (pipe_issue !== (exp_rdy & v)) begin
            bad++; $display("FAIL pipe_issue cyc=%0d got=%b exp=%b", cyc, pipe_issue, exp_rdy & v);
        end
        if (exp_vld) begin
            total++;
            if (res !== sb_q[0]) begin
                bad++; $display("FAIL res_data cyc=%0d got=%h exp=%h", cyc, res, sb_q[0]);
            end
        end
        obs_rdy    = arg_rdy;
        obs_vld    = res_vld;
        obs_res    = res;
        last_pop   = exp_vld && (rr === 1'b1);
        last_issue = exp_rdy && (v === 1'b1);
        if (r) begin
            sb_q.delete();
            av_q.delete();
        end else begin
            if (last_pop) begin
                void'(sb_q.pop_front());
                void'(av_q.pop_front());
                n_pop++;
            end
            if (last_issue) begin
                sb_q.push_back(d);
                av_q.push_back(cyc + LATENCY + 1);
                n_iss++;
            end
        end
        cyc++;
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'bx, 'x, 1'bx);
            total++;
            if (obs_rdy !== 1'b0 || obs_vld !== 1'b0) begin
                bad++; $display("FAIL reset_outputs rdy=%b vld=%b exp=0/0", obs_rdy, obs_vld);
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        total++;
        if (obs_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_release_rdy got=%b exp=1", obs_rdy);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] payload = 64'h3FF0_0000_0000_0000;
        int first = -1;
        logic [W-1:0] got = '0;
        cycle(1'b0, 1'b1, payload, 1'b1);
        for (int k = 1; k <= 2 * LATENCY; k++) begin
            cycle(1'b0, 1'b0, rnd64(), 1'b1);
            if (obs_vld === 1'b1 && first < 0) begin
                first = k;
                got   = obs_res;
            end
        end
        total++;
        if (first != LATENCY + 1) begin
            bad++; $display("FAIL single_latency got=%0d exp=%0d", first, LATENCY + 1);
        end
        total++;
        if (got !== payload) begin
            bad++; $display("FAIL single_data got=%h exp=%h", got, payload);
        end
        total++;
        if (dut.occ_q !== '0) begin
            bad++; $display("FAIL single_occ got=%0d exp=0", dut.occ_q);
        end
    endtask

    task automatic test_back_to_back();
        int zeros = 0;
        int p0 = n_pop;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'b1, rnd64(), 1'b1);
            if (obs_rdy !== 1'b1) zeros++;
        end
        for (int i = 0; i < LATENCY + 1; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        total++;
        if (zeros != 0) begin
            bad++; $display("FAIL b2b_rdy_drops got=%0d exp=0", zeros);
        end
        total++;
        if (n_pop - p0 != 1000) begin
            bad++; $display("FAIL b2b_results got=%0d exp=1000", n_pop - p0);
        end
    endtask

    task automatic test_full();
        int i0 = n_iss;
        int p0 = n_pop;
        logic rdy_first, rdy_second;
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0);
        total++;
        if (n_iss - i0 != DEPTH) begin
            bad++; $display("FAIL full_accepts got=%0d exp=%0d", n_iss - i0, DEPTH);
        end
        total++;
        if (obs_rdy !== 1'b0) begin
            bad++; $display("FAIL full_rdy got=%b exp=0", obs_rdy);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        rdy_first = obs_rdy;
        cycle(1'b0, 1'b0, '0, 1'b1);
        rdy_second = obs_rdy;
        for (int i = 2; i < DEPTH; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        total++;
        if (rdy_first !== 1'b0 || rdy_second !== 1'b1) begin
            bad++; $display("FAIL full_rdy_return got=%b%b exp=01", rdy_first, rdy_second);
        end
        total++;
        if (n_pop - p0 != DEPTH) begin
            bad++; $display("FAIL full_drain got=%0d exp=%0d", n_pop - p0, DEPTH);
        end
    endtask

    task automatic test_random();
        int gap = 0;
        int i0 = n_iss;
        int p0 = n_pop;
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b0, gap == 0, rnd64(), 1'($urandom_range(0, 1)));
            if (gap > 0) gap--;
            else if (last_issue) gap = $urandom_range(0, 22);
        end
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        total++;
        if (sb_q.size() != 0 || (n_iss - i0) != (n_pop - p0)) begin
            bad++; $display("FAIL random_balance accepts=%0d results=%0d left=%0d",
                            n_iss - i0, n_pop - p0, sb_q.size());
        end
    endtask

    task automatic test_reset_mid_flight();
        int vld_seen = 0;
        int first = -1;
        int results = 0;
        logic [W-1:0] payload = rnd64();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0);
        for (int i = 0; i < LATENCY + 1; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2 * LATENCY; i++) begin
            cycle(1'b0, 1'b0, rnd64(), 1'b1);
            if (obs_vld === 1'b1) vld_seen++;
        end
        total++;
        if (vld_seen != 0) begin
            bad++; $display("FAIL mid_reset_discard got=%0d exp=0", vld_seen);
        end
        cycle(1'b0, 1'b1, payload, 1'b1);
        for (int k = 1; k <= 3 * LATENCY; k++) begin
            cycle(1'b0, 1'b0, rnd64(), 1'b1);
            if (obs_vld === 1'b1) begin
                results++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (first != LATENCY + 1 || results != 1) begin
            bad++; $display("FAIL mid_reset_new_op latency=%0d count=%0d exp=%0d/1",
                            first, results, LATENCY + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_random();
        test_reset_mid_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
